// File: rtl/event_pkg.sv
// Shared definitions for the event arbiter: default field widths, slot state encoding
// and the index-width helper.
package event_pkg;

  localparam int unsigned DEF_X_W = 2;
  localparam int unsigned DEF_Y_W = 2;
  localparam int unsigned DEF_T_W = 2;
  localparam int unsigned DEF_P_W = 2;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  // Width of a source index, never narrower than one bit.
  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/event_rr_arbiter_if.sv
// Request and output-slot bundle of the event arbiter. acc_cnt exists only when
// ARB_ACC_CNT_EN is defined.
interface event_rr_arbiter_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned X_W   = event_pkg::DEF_X_W,
  parameter int unsigned Y_W   = event_pkg::DEF_Y_W,
  parameter int unsigned T_W   = event_pkg::DEF_T_W,
  parameter int unsigned P_W   = event_pkg::DEF_P_W
);
  import event_pkg::*;
  localparam int unsigned SRC_W = idx_width(N_REQ);

  logic [N_REQ-1:0]     req_valid;
  logic [N_REQ-1:0]     req_ready;
  logic [N_REQ*X_W-1:0] req_x;
  logic [N_REQ*Y_W-1:0] req_y;
  logic [N_REQ*T_W-1:0] req_t;
  logic [N_REQ*P_W-1:0] req_p;
  logic                 out_valid;
  logic                 out_ready;
  logic [X_W-1:0]       out_x;
  logic [Y_W-1:0]       out_y;
  logic [T_W-1:0]       out_t;
  logic [P_W-1:0]       out_p;
  logic [SRC_W-1:0]     out_src;
`ifdef ARB_ACC_CNT_EN
  logic [N_REQ*8-1:0]   acc_cnt;
`endif

  // Environment side: sources and the downstream filter.
  modport master (
    output req_valid, req_x, req_y, req_t, req_p, out_ready,
`ifdef ARB_ACC_CNT_EN
    input  acc_cnt,
`endif
    input  req_ready, out_valid, out_x, out_y, out_t, out_p, out_src
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_x, req_y, req_t, req_p, out_ready,
`ifdef ARB_ACC_CNT_EN
    output acc_cnt,
`endif
    output req_ready, out_valid, out_x, out_y, out_t, out_p, out_src
  );

endinterface

// File: rtl/event_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid request at or after ptr, wrapping.
// Reused by the multi-lane schedulers.
module rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned SRC_W = 2
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [SRC_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [SRC_W-1:0] idx
);

  int unsigned cand;
  logic        found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = 32'(ptr) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!found && req_valid[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = SRC_W'(cand);
      end
    end
  end

endmodule

// File: rtl/event_rr_arbiter.sv
// Round-robin arbiter feeding one registered output slot shared by N_REQ event sources.
// Optional per-source saturating accept counters with ARB_ACC_CNT_EN.
module event_rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned X_W   = event_pkg::DEF_X_W,
  parameter int unsigned Y_W   = event_pkg::DEF_Y_W,
  parameter int unsigned T_W   = event_pkg::DEF_T_W,
  parameter int unsigned P_W   = event_pkg::DEF_P_W
) (
  input logic               clk,
  input logic               rst_n,
  event_rr_arbiter_if.slave bus
);
  import event_pkg::*;
  localparam int unsigned SRC_W = idx_width(N_REQ);

  slot_state_e      state_q;
  logic [SRC_W-1:0] ptr_q;
  logic [SRC_W-1:0] win_idx;
  logic [N_REQ-1:0] grant;
  logic             slot_free;
  logic             xfer;
  logic [X_W-1:0]   x_q;
  logic [Y_W-1:0]   y_q;
  logic [T_W-1:0]   t_q;
  logic [P_W-1:0]   p_q;
  logic [SRC_W-1:0] src_q;

  rr_pick #(
    .N_REQ(N_REQ),
    .SRC_W(SRC_W)
  ) u_pick (
    .req_valid(bus.req_valid),
    .ptr      (ptr_q),
    .grant    (grant),
    .idx      (win_idx)
  );

  // Grant is one-hot and only set on a valid request, so any ready bit is a transfer.
  // Ready is forced low while reset is asserted.
  assign slot_free     = (state_q == SLOT_EMPTY) | bus.out_ready;
  assign xfer          = slot_free & rst_n & (|grant);
  assign bus.req_ready = xfer ? grant : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SLOT_EMPTY;
      ptr_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      t_q     <= '0;
      p_q     <= '0;
      src_q   <= '0;
    end else if (xfer) begin
      state_q <= SLOT_FULL;
      ptr_q   <= (win_idx == SRC_W'(N_REQ - 1)) ? '0 : win_idx + SRC_W'(1);
      x_q     <= bus.req_x[int'(win_idx)*X_W +: X_W];
      y_q     <= bus.req_y[int'(win_idx)*Y_W +: Y_W];
      t_q     <= bus.req_t[int'(win_idx)*T_W +: T_W];
      p_q     <= bus.req_p[int'(win_idx)*P_W +: P_W];
      src_q   <= win_idx;
    end else if (bus.out_ready) begin
      state_q <= SLOT_EMPTY;
    end
  end

  assign bus.out_valid = (state_q == SLOT_FULL);
  assign bus.out_x     = x_q;
  assign bus.out_y     = y_q;
  assign bus.out_t     = t_q;
  assign bus.out_p     = p_q;
  assign bus.out_src   = src_q;

`ifdef ARB_ACC_CNT_EN
  logic [N_REQ-1:0][7:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (bus.req_ready[i] && (cnt_q[i] != 8'hFF)) cnt_q[i] <= cnt_q[i] + 8'd1;
      end
    end
  end

  assign bus.acc_cnt = cnt_q;
`endif

endmodule
